// File: rtl/i2c_pkg.sv
// Shared I2C definitions: responder FSM state encoding and bus acknowledge levels.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    IGNORE
  } i2c_state_t;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// Two-flop synchronizers for the I2C bus lines plus SCL edge and START/STOP detection.
module i2c_bus_sync (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);

  // [0],[1] form the synchronizer; [2] holds the previous synchronized value
  logic [2:0] r_scl;
  logic [2:0] r_sda;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_scl <= '1;
      r_sda <= '1;
    end else begin
      r_scl <= {r_scl[1:0], i_scl};
      r_sda <= {r_sda[1:0], i_sda};
    end
  end

  assign o_sda      = r_sda[1];
  assign o_scl_rise = r_scl[1] & ~r_scl[2];
  assign o_scl_fall = ~r_scl[1] & r_scl[2];
  assign o_start    = r_scl[1] & r_sda[2] & ~r_sda[1];
  assign o_stop     = r_scl[1] & ~r_sda[2] & r_sda[1];

endmodule

// File: rtl/i2c_slave_responder.sv
// I2C slave exposing a byte register file: pointer write, data write, sequential read.
// state             | meaning
// IDLE / IGNORE     | bus free / transfer not for us, wait for START or STOP
// ADDR / PTR / WDATA| shifting in address, register pointer, write data
// RDATA             | shifting out regs[ptr] snapshot
// *_ACK             | ninth clock: we pull ACK, or sample the master's ACK on reads
module i2c_slave_responder
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h42,
  parameter int         NUM_REGS   = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        scl,
  inout  wire                         sda,
  input  logic [$clog2(NUM_REGS)-1:0] host_addr,
  input  logic                        host_we,
  input  logic [7:0]                  host_wdata,
  output logic [7:0]                  host_rdata,
  output logic                        i2c_wr_strobe,
  output logic [$clog2(NUM_REGS)-1:0] i2c_wr_index,
  output logic                        busy
);

  localparam int PW = $clog2(NUM_REGS);

  i2c_state_t    r_state;
  logic [3:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic [PW-1:0] r_ptr;
  logic          r_rw;
  logic          r_mack;
  logic          r_sda_oe;
  logic [7:0]    r_regs [NUM_REGS];

  logic          w_sda, w_rise, w_fall, w_start, w_stop;
  logic [PW-1:0] w_ptr_inc;

  assign w_ptr_inc = r_ptr + PW'(1);
  assign sda       = r_sda_oe ? 1'b0 : 1'bz;

  i2c_bus_sync u_sync (
    .i_clock    (clock),
    .i_reset    (reset),
    .i_scl      (scl),
    .i_sda      (sda),
    .o_sda      (w_sda),
    .o_scl_rise (w_rise),
    .o_scl_fall (w_fall),
    .o_start    (w_start),
    .o_stop     (w_stop)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) host_rdata <= 8'h00;
    else       host_rdata <= r_regs[host_addr];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_bit_cnt     <= 4'd0;
      r_shift       <= 8'h00;
      r_ptr         <= '0;
      r_rw          <= 1'b0;
      r_mack        <= I2C_NACK;
      r_sda_oe      <= 1'b0;
      i2c_wr_strobe <= 1'b0;
      i2c_wr_index  <= '0;
      busy          <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= 8'h00;
    end else begin
      i2c_wr_strobe <= 1'b0;
      // host write first so a same-cycle I2C write to the same index overrides it
      if (host_we) r_regs[host_addr] <= host_wdata;
      if (w_stop) begin
        r_state  <= IDLE;
        r_sda_oe <= 1'b0;
        busy     <= 1'b0;
      end else if (w_start) begin
        r_state   <= ADDR;
        r_bit_cnt <= 4'd0;
        r_sda_oe  <= 1'b0;
      end else begin
        if (w_rise && r_bit_cnt != 4'd8) begin
          if (r_state inside {ADDR, PTR, WDATA}) begin
            r_shift   <= {r_shift[6:0], w_sda};
            r_bit_cnt <= r_bit_cnt + 4'd1;
          end else if (r_state == RDATA) begin
            r_bit_cnt <= r_bit_cnt + 4'd1;
          end else if (r_state == RDATA_ACK) begin
            r_mack <= w_sda;
          end
        end
        if (w_fall) begin
          case (r_state)
            ADDR: if (r_bit_cnt == 4'd8) begin
              r_bit_cnt <= 4'd0;
              if (r_shift[7:1] == SLAVE_ADDR) begin
                r_state  <= ADDR_ACK;
                r_sda_oe <= 1'b1;
                r_rw     <= r_shift[0];
                busy     <= 1'b1;
              end else begin
                r_state <= IGNORE;
                busy    <= 1'b0;
              end
            end
            ADDR_ACK: if (r_rw) begin
              r_state  <= RDATA;
              r_shift  <= r_regs[r_ptr];
              r_sda_oe <= ~r_regs[r_ptr][7];
            end else begin
              r_state  <= PTR;
              r_sda_oe <= 1'b0;
            end
            PTR: if (r_bit_cnt == 4'd8) begin
              r_bit_cnt <= 4'd0;
              r_ptr     <= r_shift[PW-1:0];
              r_state   <= PTR_ACK;
              r_sda_oe  <= 1'b1;
            end
            PTR_ACK, WDATA_ACK: begin
              r_state  <= WDATA;
              r_sda_oe <= 1'b0;
            end
            WDATA: if (r_bit_cnt == 4'd8) begin
              r_bit_cnt      <= 4'd0;
              r_regs[r_ptr]  <= r_shift;
              i2c_wr_strobe  <= 1'b1;
              i2c_wr_index   <= r_ptr;
              r_ptr          <= w_ptr_inc;
              r_state        <= WDATA_ACK;
              r_sda_oe       <= 1'b1;
            end
            RDATA: if (r_bit_cnt == 4'd8) begin
              r_bit_cnt <= 4'd0;
              r_state   <= RDATA_ACK;
              r_sda_oe  <= 1'b0;
            end else if (r_bit_cnt != 4'd0) begin
              r_shift  <= {r_shift[6:0], 1'b0};
              r_sda_oe <= ~r_shift[6];
            end
            RDATA_ACK: if (r_mack == I2C_NACK) begin
              r_state  <= IGNORE;
              r_sda_oe <= 1'b0;
            end else begin
              r_ptr    <= w_ptr_inc;
              r_shift  <= r_regs[w_ptr_inc];
              r_sda_oe <= ~r_regs[w_ptr_inc][7];
              r_state  <= RDATA;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Directed bench for i2c_slave_responder: table of write transactions plus read/collision/reset sequences.
module tb_i2c_slave_responder;
  import i2c_pkg::*;

  localparam int H = 8;

  logic       clock      = 1'b0;
  logic       reset      = 1'b1;
  logic       scl        = 1'b1;
  logic       m_low      = 1'b0;
  logic [3:0] host_addr  = 4'd0;
  logic       host_we    = 1'b0;
  logic [7:0] host_wdata = 8'h00;
  logic [7:0] host_rdata;
  logic       i2c_wr_strobe;
  logic [3:0] i2c_wr_index;
  logic       busy;
  wire        sda_bus;

  pullup (sda_bus);
  assign sda_bus = m_low ? 1'b0 : 1'bz;

  i2c_slave_responder #(.SLAVE_ADDR(7'h42), .NUM_REGS(16)) dut (
    .clock         (clock),
    .reset         (reset),
    .scl           (scl),
    .sda           (sda_bus),
    .host_addr     (host_addr),
    .host_we       (host_we),
    .host_wdata    (host_wdata),
    .host_rdata    (host_rdata),
    .i2c_wr_strobe (i2c_wr_strobe),
    .i2c_wr_index  (i2c_wr_index),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] addr_b;
    logic [7:0] ptr;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       ack;
    logic [3:0] i0;
    logic [3:0] i1;
  } wr_vec_t;

  wr_vec_t    vecs [4];
  logic [7:0] model_regs [16];
  int         strobe_q [$];
  int         checks = 0;
  int         errors = 0;
  logic       ack, bz;
  logic [7:0] rb;

  always @(negedge clock) if (i2c_wr_strobe) strobe_q.push_back(int'(i2c_wr_index));

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic i2c_start();
    m_low = 1'b0; clks(H); scl = 1'b1; clks(H); m_low = 1'b1; clks(H); scl = 1'b0; clks(2);
  endtask

  task automatic i2c_stop();
    m_low = 1'b1; clks(H); scl = 1'b1; clks(H); m_low = 1'b0; clks(H);
  endtask

  task automatic wr_byte(input logic [7:0] b, input logic collide, output logic ack_seen, output logic busy_seen);
    for (int i = 7; i >= 0; i--) begin
      m_low = ~b[i]; clks(H); scl = 1'b1; clks(H); scl = 1'b0;
      if (collide && i == 0) begin
        // host strobe lands on the exact cycle the synchronized SCL fall commits the byte
        clks(2); host_we = 1'b1; clks(1); host_we = 1'b0; clks(1);
      end else begin
        clks(2);
      end
    end
    m_low = 1'b0; clks(H); scl = 1'b1; clks(H/2);
    ack_seen  = (sda_bus == 1'b0);
    busy_seen = busy;
    clks(H/2); scl = 1'b0; clks(2);
  endtask

  task automatic rd_byte(input logic master_ack, output logic [7:0] b);
    m_low = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      clks(H); scl = 1'b1; clks(H/2); b[i] = sda_bus; clks(H/2); scl = 1'b0; clks(2);
    end
    m_low = (master_ack == I2C_ACK); clks(H); scl = 1'b1; clks(H); scl = 1'b0; clks(2);
    m_low = 1'b0;
  endtask

  task automatic host_write(input logic [3:0] a, input logic [7:0] d);
    host_addr = a; host_wdata = d; host_we = 1'b1; clks(1); host_we = 1'b0;
    model_regs[a] = d;
  endtask

  task automatic check_regs();
    for (int a = 0; a < 16; a++) begin
      host_addr = a[3:0]; clks(2);
      check($sformatf("reg[%0d]", a), int'(host_rdata), int'(model_regs[a]));
    end
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : main
    vecs[0] = '{8'h84, 8'h03, 8'hA5, 8'h5A, 1'b1, 4'd3,  4'd4};
    vecs[1] = '{8'h86, 8'h09, 8'hEE, 8'hDD, 1'b0, 4'd0,  4'd0};
    vecs[2] = '{8'h84, 8'h25, 8'h10, 8'h20, 1'b1, 4'd5,  4'd6};
    vecs[3] = '{8'h84, 8'h0F, 8'h11, 8'h22, 1'b1, 4'd15, 4'd0};
    for (int i = 0; i < 16; i++) model_regs[i] = 8'h00;

    clks(4);
    check("rst_host_rdata", int'(host_rdata), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_strobe", int'(i2c_wr_strobe), 0);
    check("rst_wr_index", int'(i2c_wr_index), 0);
    check("rst_sda", int'(sda_bus), 1);
    reset = 1'b0;
    clks(4);

    for (int k = 0; k < 4; k++) begin
      strobe_q.delete();
      i2c_start();
      wr_byte(vecs[k].addr_b, 1'b0, ack, bz);
      check($sformatf("v%0d_addr_ack", k), int'(ack), int'(vecs[k].ack));
      check($sformatf("v%0d_busy", k), int'(bz), int'(vecs[k].ack));
      wr_byte(vecs[k].ptr, 1'b0, ack, bz);
      check($sformatf("v%0d_ptr_ack", k), int'(ack), int'(vecs[k].ack));
      wr_byte(vecs[k].d0, 1'b0, ack, bz);
      check($sformatf("v%0d_d0_ack", k), int'(ack), int'(vecs[k].ack));
      wr_byte(vecs[k].d1, 1'b0, ack, bz);
      check($sformatf("v%0d_d1_ack", k), int'(ack), int'(vecs[k].ack));
      i2c_stop();
      check($sformatf("v%0d_busy_after_stop", k), int'(busy), 0);
      if (vecs[k].ack) begin
        model_regs[vecs[k].i0] = vecs[k].d0;
        model_regs[vecs[k].i1] = vecs[k].d1;
      end
      check($sformatf("v%0d_strobe_count", k), strobe_q.size(), vecs[k].ack ? 2 : 0);
      if (vecs[k].ack && strobe_q.size() == 2) begin
        check($sformatf("v%0d_strobe_idx0", k), strobe_q[0], int'(vecs[k].i0));
        check($sformatf("v%0d_strobe_idx1", k), strobe_q[1], int'(vecs[k].i1));
      end
      check_regs();
    end

    // pointer left at 1 by the wrapping write must survive the STOP
    host_write(4'd1, 8'h77);
    i2c_start();
    wr_byte(8'h85, 1'b0, ack, bz);
    check("ptr_persist_addr_ack", int'(ack), 1);
    rd_byte(I2C_NACK, rb);
    check("ptr_persist_read", int'(rb), 8'h77);
    i2c_stop();

    // pointer write, repeated START, two-byte read
    host_write(4'd2, 8'h3C);
    i2c_start();
    wr_byte(8'h84, 1'b0, ack, bz);
    check("rs_addr_ack", int'(ack), 1);
    wr_byte(8'h02, 1'b0, ack, bz);
    check("rs_ptr_ack", int'(ack), 1);
    i2c_start();
    wr_byte(8'h85, 1'b0, ack, bz);
    check("rs_read_addr_ack", int'(ack), 1);
    check("rs_busy", int'(bz), 1);
    rd_byte(I2C_ACK, rb);
    check("rs_read0", int'(rb), 8'h3C);
    rd_byte(I2C_NACK, rb);
    check("rs_read1", int'(rb), 8'hA5);
    clks(3);
    check("rs_sda_released", int'(sda_bus), 1);
    check("rs_busy_before_stop", int'(busy), 1);
    i2c_stop();
    check("rs_busy_after_stop", int'(busy), 0);

    // host and I2C write index 5 in the same cycle
    strobe_q.delete();
    host_addr = 4'd5; host_wdata = 8'h01;
    i2c_start();
    wr_byte(8'h84, 1'b0, ack, bz);
    wr_byte(8'h05, 1'b0, ack, bz);
    wr_byte(8'h99, 1'b1, ack, bz);
    check("col_data_ack", int'(ack), 1);
    i2c_stop();
    model_regs[5] = 8'h99;
    check("col_strobe_count", strobe_q.size(), 1);
    if (strobe_q.size() == 1) check("col_strobe_idx", strobe_q[0], 5);
    host_addr = 4'd5; clks(2);
    check("col_reg5", int'(host_rdata), 8'h99);

    // reset during the fourth bit of a read (ptr now 6, bit 4 of 0xE0 is 0)
    host_write(4'd6, 8'hE0);
    i2c_start();
    wr_byte(8'h85, 1'b0, ack, bz);
    check("rr_addr_ack", int'(ack), 1);
    m_low = 1'b0;
    for (int i = 0; i < 3; i++) begin
      clks(H); scl = 1'b1; clks(H); scl = 1'b0; clks(2);
    end
    clks(H); scl = 1'b1; clks(H/2);
    check("rr_sda_driven_low", int'(sda_bus), 0);
    reset = 1'b1;
    #1;
    check("rr_sda_async_release", int'(sda_bus), 1);
    check("rr_busy_async_clear", int'(busy), 0);
    clks(2);
    reset = 1'b0;
    scl = 1'b0;
    clks(H);
    for (int i = 0; i < 16; i++) model_regs[i] = 8'h00;
    check_regs();

    strobe_q.delete();
    i2c_start();
    wr_byte(8'h84, 1'b0, ack, bz);
    check("post_rst_addr_ack", int'(ack), 1);
    wr_byte(8'h07, 1'b0, ack, bz);
    check("post_rst_ptr_ack", int'(ack), 1);
    wr_byte(8'hC3, 1'b0, ack, bz);
    check("post_rst_data_ack", int'(ack), 1);
    i2c_stop();
    model_regs[7] = 8'hC3;
    check("post_rst_strobe_count", strobe_q.size(), 1);
    if (strobe_q.size() == 1) check("post_rst_strobe_idx", strobe_q[0], 7);
    host_addr = 4'd7; clks(2);
    check("post_rst_reg7", int'(host_rdata), 8'hC3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
